// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG colour-conversion stage.
// Holds the channel encoding, the 8-fractional-bit YCbCr->RGB coefficients,
// the block/row typedefs and the saturating clamp used by the pixel converter.
package jpeg_pkg;

    // Channel tag carried on ch_in; any other code is an invalid channel.
    typedef enum logic [1:0] {
        CH_Y  = 2'd0,
        CH_CB = 2'd1,
        CH_CR = 2'd2
    } ch_e;

    // Conversion FSM: collect the three blocks, then stream eight RGB rows.
    typedef enum logic {
        ST_LOAD    = 1'b0,
        ST_CONVERT = 1'b1
    } state_e;

    // Coefficients scaled by 2^8 (1.402, 0.344, 0.714, 1.772).
    localparam int K_R_CR = 359;
    localparam int K_G_CB = 88;
    localparam int K_G_CR = 183;
    localparam int K_B_CB = 454;

    // Accumulator width: |Y<<8| + 454*128 stays inside 18 bits; two bits spare.
    localparam int ACC_W = 20;

    typedef logic signed [7:0] s8_t;
    typedef logic        [7:0] u8_t;
    typedef s8_t [7:0]         s8_row_t;
    typedef s8_row_t [7:0]     block_t;
    typedef u8_t [7:0]         rgb_row_t;

    // Saturate a signed accumulator result into 0..255.
    function automatic u8_t clamp_u8(input logic signed [ACC_W-1:0] v);
        if (v[ACC_W-1]) begin
            return 8'd0;
        end else if (|v[ACC_W-2:8]) begin
            return 8'd255;
        end else begin
            return v[7:0];
        end
    endfunction

endpackage

// File: rtl/ycc2rgb_pixel.sv
// Combinational single-pixel YCbCr -> RGB converter (signed level-shifted
// inputs, clamped unsigned outputs). Rounding of the fixed-point result is
// selected at build time by YCC2RGB_ROUND_EN (defined: round half up,
// undefined: floor).
module ycc2rgb_pixel
    import jpeg_pkg::*;
#(
    parameter int FRAC = 8
) (
    input  logic signed [7:0] y,
    input  logic signed [7:0] cb,
    input  logic signed [7:0] cr,
    output logic        [7:0] r,
    output logic        [7:0] g,
    output logic        [7:0] b
);

    localparam logic signed [ACC_W-1:0] KRCR   = ACC_W'(K_R_CR);
    localparam logic signed [ACC_W-1:0] KGCB   = ACC_W'(K_G_CB);
    localparam logic signed [ACC_W-1:0] KGCR   = ACC_W'(K_G_CR);
    localparam logic signed [ACC_W-1:0] KBCB   = ACC_W'(K_B_CB);
    localparam logic signed [ACC_W-1:0] OFFSET = ACC_W'(128);
`ifdef YCC2RGB_ROUND_EN
    localparam logic signed [ACC_W-1:0] HALF   = ACC_W'(1 << (FRAC - 1));
`else
    localparam logic signed [ACC_W-1:0] HALF   = '0;
`endif

    logic signed [ACC_W-1:0] y_ext, cb_ext, cr_ext;
    logic signed [ACC_W-1:0] r_acc, g_acc, b_acc;
    logic signed [ACC_W-1:0] r_val, g_val, b_val;

    // Fixed-point matrix multiply, arithmetic shift (floor), re-centre and clamp.
    always_comb begin
        y_ext  = ACC_W'(y);
        cb_ext = ACC_W'(cb);
        cr_ext = ACC_W'(cr);

        r_acc  = (y_ext <<< FRAC) + KRCR * cr_ext + HALF;
        g_acc  = (y_ext <<< FRAC) - KGCB * cb_ext - KGCR * cr_ext + HALF;
        b_acc  = (y_ext <<< FRAC) + KBCB * cb_ext + HALF;

        r_val  = (r_acc >>> FRAC) + OFFSET;
        g_val  = (g_acc >>> FRAC) + OFFSET;
        b_val  = (b_acc >>> FRAC) + OFFSET;

        r      = clamp_u8(r_val);
        g      = clamp_u8(g_val);
        b      = clamp_u8(b_val);
    end

endmodule

// File: rtl/ycc2rgb_block.sv
// Colour-conversion stage after chroma supersampling. Buffers one Y, Cb and
// Cr 8x8 block (any arrival order), then streams eight converted RGB rows
// over a valid/ready handshake. Build option YCC2RGB_ROUND_EN selects
// round-half-up instead of floor in the per-pixel converter.
module ycc2rgb_block
    import jpeg_pkg::*;
#(
    parameter int FRAC = 8,
    parameter int CH   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    output logic                     ready_in,
    input  logic [$clog2(CH+1)-1:0]  ch_in,
    input  block_t                   block_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_row,
    output logic                     out_last,
    output rgb_row_t                 r_row,
    output rgb_row_t                 g_row,
    output rgb_row_t                 b_row
);

    localparam int CHW = $clog2(CH + 1);

    state_e   state;
    logic     y_full, cb_full, cr_full;
    block_t   y_buf, cb_buf, cr_buf;
    logic     is_y, is_cb, is_cr;
    logic     accept;
    logic     row_hs;
    logic [2:0] sel_row;
    rgb_row_t r_conv, g_conv, b_conv;

    assign is_y   = (ch_in == CHW'(CH_Y));
    assign is_cb  = (ch_in == CHW'(CH_CB));
    assign is_cr  = (ch_in == CHW'(CH_CR));
    assign accept = valid_in && ready_in;
    assign row_hs = out_valid && out_ready;

    // Accept a block only into an empty buffer; unknown channels are swallowed.
    always_comb begin
        ready_in = 1'b0;
        if (rst && state == ST_LOAD) begin
            if (is_y) begin
                ready_in = !y_full;
            end else if (is_cb) begin
                ready_in = !cb_full;
            end else if (is_cr) begin
                ready_in = !cr_full;
            end else begin
                ready_in = 1'b1;
            end
        end
    end

    // NOTE: the block buffers carry no reset; the full flags alone say whether contents are meaningful.
    always_ff @(posedge clk) begin
        if (accept && is_y)  y_buf  <= block_in;
        if (accept && is_cb) cb_buf <= block_in;
        if (accept && is_cr) cr_buf <= block_in;
    end

    // Row feeding the converters: row 0 while loading, otherwise the row after the one on display.
    always_comb begin
        sel_row = 3'd0;
        if (state == ST_CONVERT) begin
            sel_row = out_row + 3'd1;
        end
    end

    // Eight converters produce one full row per cycle.
    for (genvar c = 0; c < 8; c++) begin : g_pix
        ycc2rgb_pixel #(.FRAC(FRAC)) u_pix (
            .y  (y_buf[sel_row][c]),
            .cb (cb_buf[sel_row][c]),
            .cr (cr_buf[sel_row][c]),
            .r  (r_conv[c]),
            .g  (g_conv[c]),
            .b  (b_conv[c])
        );
    end

    // Load/convert FSM with registered row outputs, held while out_ready is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_LOAD;
            y_full    <= 1'b0;
            cb_full   <= 1'b0;
            cr_full   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= 3'd0;
            r_row     <= '0;
            g_row     <= '0;
            b_row     <= '0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    if (accept && is_y)  y_full  <= 1'b1;
                    if (accept && is_cb) cb_full <= 1'b1;
                    if (accept && is_cr) cr_full <= 1'b1;
                    if (y_full && cb_full && cr_full) begin
                        state     <= ST_CONVERT;
                        out_valid <= 1'b1;
                        out_row   <= 3'd0;
                        out_last  <= 1'b0;
                        r_row     <= r_conv;
                        g_row     <= g_conv;
                        b_row     <= b_conv;
                    end
                end
                ST_CONVERT: begin
                    if (row_hs) begin
                        if (out_row == 3'd7) begin
                            state     <= ST_LOAD;
                            y_full    <= 1'b0;
                            cb_full   <= 1'b0;
                            cr_full   <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_row   <= 3'd0;
                        end else begin
                            out_row   <= out_row + 3'd1;
                            out_last  <= (out_row == 3'd6);
                            r_row     <= r_conv;
                            g_row     <= g_conv;
                            b_row     <= b_conv;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule
